regfile32: RTL and testbench
============================

Name: regfile32

Overview:
- 32x32-bit MIPS general-purpose register file; sits directly downstream of the write-address mux (consumes its 5-bit destination address).
- Two combinational read ports (rs, rt) feed the ALU and store-data path; one synchronous write port is driven by the writeback result.
- $zero (r0) is hardwired to 0.
- Includes a committed-write counter for debug/performance visibility.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- read_addr1  input  ADDR_W  rs index.
- read_addr2  input  ADDR_W  rt index.
- write_addr  input  ADDR_W  destination index, from the RegDst mux output.
- write_data  input  DATA_W  writeback value.
- RegWrite  input  1  write enable.
- read_data1  output  DATA_W  contents of read_addr1.
- read_data2  output  DATA_W  contents of read_addr2.
- wr_count  output  CNT_W  number of committed writes since reset.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All 32 registers are cleared to 0 and wr_count is cleared to 0 in that same cycle.
  - RegWrite is ignored while rst=1; reset has priority over a simultaneous write.
- Write:
  - At a rising edge with rst=0, RegWrite=1 and write_addr!=0, reg[write_addr] <= write_data and wr_count increments by 1.
  - Latency 1: the new value is visible on the read ports after that edge.
- Writes to r0 are discarded; wr_count does not increment for them.
- RegWrite=0: no state changes; wr_count holds.
- Reads:
  - Purely combinational from current state (zero cycles).
  - read_data = 0 whenever the address is 0, regardless of storage contents.
  - Both ports may read the same address simultaneously.
- Read-during-write, same address, without the optional feature: the read returns the old value until the edge.
- wr_count wraps modulo 2**CNT_W (all-ones + 1 -> 0); there is no saturation.
- No X propagation: every register has a defined value from the first reset onward.
- Reset asserted mid-sequence (e.g. between back-to-back writes) discards any write presented in the reset cycle.
- Outputs during reset follow the combinational read of the registers; after the reset edge they read 0.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: if RegWrite=1, rst=0, write_addr!=0 and read_addrN==write_addr, read_dataN = write_data in the same cycle (internal forwarding for pipelined use). r0 still reads 0. Bypass is suppressed while rst=1.
- Not defined: no forwarding; reads return stored state only.

Decomposition:
- Shared package (mips_pkg):
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, ZERO_REG=5'd0.
  - Named indices: REG_SP=29, REG_RA=31.
- No sub-module. The storage array, write logic, counter and read/bypass muxing are kept inline; the read path is a single function reused by both ports.

Test Plan:
- Reset then read all 32 addresses on both ports -> every read_data = 0; wr_count = 0.
- Write r5 <= 32'hDEADBEEF (RegWrite=1), next cycle read_addr1=5, read_addr2=5 -> both outputs = 32'hDEADBEEF; wr_count = 1.
- Write r0 <= 32'hFFFFFFFF -> read_addr1=0 returns 0; wr_count unchanged.
- Same-cycle write r7 <= 32'h12345678 and read_addr2=7:
  - Without the macro: returns the prior value 0.
  - With REGFILE_WRITE_BYPASS_EN: returns 32'h12345678.
- RegWrite=0 with write_addr=9, write_data=32'hA5A5A5A5 -> r9 stays 0; wr_count holds.
- Write r31 <= 32'h00400000, then assert rst in the same cycle as a write r2 <= 32'h1 -> after the edge r31 = 0, r2 = 0, wr_count = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants used by the register file
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  localparam int REG_SP = 29;
  localparam int REG_RA = 31;

endpackage

// File: rtl/regfile32.sv
// rtl/regfile32.sv - 32x32 MIPS register file, r0 hardwired to 0, committed-write counter
// Optional same-cycle write forwarding to both read ports: REGFILE_WRITE_BYPASS_EN
module regfile32
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              wr_en;

  // Writes aimed at r0 are not commits: they neither store nor count.
  assign wr_en = RegWrite && (write_addr != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) regs_q[write_addr] <= write_data;
      cnt_q <= cnt_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward the in-flight writeback; reset blocks it so reads show stored state.
    if (!rst && wr_en && (addr == write_addr)) return write_data;
`endif
    return regs_q[addr];
  endfunction

  always_comb begin
    read_data1 = read_port(read_addr1);
    read_data2 = read_port(read_addr2);
  end

  assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile32.sv
// tb/tb_regfile32.sv - scoreboard bench for regfile32 (both REGFILE_WRITE_BYPASS_EN builds)
module tb_regfile32;

  logic        clk;
  logic        rst;
  logic [4:0]  read_addr1, read_addr2, write_addr;
  logic [31:0] write_data;
  logic        RegWrite;
  logic [31:0] read_data1, read_data2, wr_count;
  logic [31:0] s_rd1, s_rd2;
  logic [1:0]  s_cnt;

  regfile32 dut (
    .clk(clk), .rst(rst),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .write_addr(write_addr), .write_data(write_data), .RegWrite(RegWrite),
    .read_data1(read_data1), .read_data2(read_data2), .wr_count(wr_count)
  );

  // Narrow counter instance so the modulo wrap is reachable in a few writes.
  regfile32 #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .write_addr(write_addr), .write_data(write_data), .RegWrite(RegWrite),
    .read_data1(s_rd1), .read_data2(s_rd2), .wr_count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 8'hA5, b};
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      case (c.port)
        0:       act = read_data1;
        1:       act = read_data2;
        2:       act = wr_count;
        default: act = {30'd0, s_cnt};
      endcase
      n_checks++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  task automatic expect_v(input string name, input int port, input logic [31:0] v);
    chk_t c;
    c.name = name; c.port = port; c.exp = v;
    q.push_back(c);
  endtask

  task automatic expect_cnt(input string name);
    expect_v({name, "_cnt"}, 2, 32'(exp_cnt));
    expect_v({name, "_cnt_small"}, 3, 32'(exp_cnt % 4));
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic r);
    read_addr1 = a1; read_addr2 = a2; RegWrite = we;
    write_addr = wa; write_data = wd; rst = r;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    step;

    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0, 1'b0);
      expect_v($sformatf("reset_rd1_r%0d", i), 0, 32'd0);
      expect_v($sformatf("reset_rd2_r%0d", 31 - i), 1, 32'd0);
      if (i == 0) expect_cnt("reset");
      step;
    end

    drive(5'd5, 5'd6, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    expect_cnt("pre_write_r5");
    step; exp_cnt++;
    drive(5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("r5_rd1", 0, 32'hDEADBEEF);
    expect_v("r5_rd2", 1, 32'hDEADBEEF);
    expect_cnt("after_r5");
    step;

    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    expect_v("r0_during_write", 0, 32'd0);
    step;
    drive(5'd0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("r0_after_write", 0, 32'd0);
    expect_cnt("after_r0_write");
    step;

    drive(5'd5, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0);
    expect_v("rdw_other_port", 0, 32'hDEADBEEF);
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_v("rdw_r7", 1, 32'h12345678);
`else
    expect_v("rdw_r7", 1, 32'd0);
`endif
    step; exp_cnt++;
    drive(5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("r7_after", 1, 32'h12345678);
    expect_cnt("after_r7");
    step;

    drive(5'd9, 5'd9, 1'b0, 5'd9, 32'hA5A5A5A5, 1'b0);
    step;
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("r9_no_write", 0, 32'd0);
    expect_cnt("regwrite_off");
    step;

    for (int i = 1; i < 32; i++) begin
      drive(5'd0, 5'd0, 1'b1, 5'(i), pat(i), 1'b0);
      step; exp_cnt++;
      if (i == 2) begin
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        expect_cnt("small_wrap");
        step;
      end
    end
    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0, 1'b0);
      expect_v($sformatf("fill_rd1_r%0d", i), 0, (i == 0) ? 32'd0 : pat(i));
      expect_v($sformatf("fill_rd2_r%0d", 31 - i), 1, (i == 31) ? 32'd0 : pat(31 - i));
      step;
    end
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_cnt("after_fill");
    step;

    drive(5'd31, 5'd31, 1'b1, 5'd31, 32'h00400000, 1'b0);
    step; exp_cnt++;
    drive(5'd31, 5'd2, 1'b1, 5'd2, 32'h00000001, 1'b1);
    expect_v("rst_cycle_r31", 0, 32'h00400000);
    expect_v("rst_cycle_r2_no_bypass", 1, pat(2));
    expect_cnt("rst_cycle");
    step; exp_cnt = 0;
    drive(5'd31, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("post_rst_r31", 0, 32'd0);
    expect_v("post_rst_r2", 1, 32'd0);
    expect_cnt("post_rst");
    step;

    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
